// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported byte memory between IF and LS.
// Ports: clock/reset; if_* word-read port; ls_* read/write port; mem_* memory pins.
module mem_port_arbiter #(
  parameter logic [31:0] MEM_BASE     = 32'h80020000,
  parameter int unsigned MEM_BYTES    = 1048576,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_datain,
  output logic [1:0]  mem_access_size,
  output logic        mem_r_w,
  input  logic [31:0] mem_dataout
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_LS
  } owner_e;

  localparam logic [3:0]  LIMIT   = 4'(STARVE_LIMIT);
  localparam logic [32:0] WIN_END = {1'b0, MEM_BASE} + 33'(MEM_BYTES);

  logic [3:0]  starve_cnt, starve_nxt;
  owner_e      owner, owner_nxt;
  logic        rsp_err, rsp_err_nxt;
  logic        rsp_we, rsp_we_nxt;
  logic [1:0]  rsp_size, rsp_size_nxt;

  logic        if_win, ls_win, any_win;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_we;
  logic [32:0] req_bytes;
  logic        misaligned, in_window, req_ok;
  logic [31:0] ls_mask;

  always_comb begin
    if_win  = if_req && (!ls_req || starve_cnt == LIMIT);
    ls_win  = ls_req && !if_win;
    any_win = if_win || ls_win;
  end

  assign if_gnt = if_win;
  assign ls_gnt = ls_win;

  always_comb begin
    req_addr = if_win ? if_addr : ls_addr;
    req_size = if_win ? 2'b11 : ls_size;
    req_we   = ls_win && ls_we;
    unique case (1'b1)
      req_size == 2'b11: req_bytes = 33'd4;
      req_size == 2'b10: req_bytes = 33'd2;
      default:           req_bytes = 33'd1;
    endcase
    misaligned = (req_size == 2'b11 && req_addr[1:0] != 2'b00)
              || (req_size == 2'b10 && req_addr[0]);
    // 33-bit sum so an access near 2^32 cannot wrap back into the window
    in_window  = (req_addr >= MEM_BASE)
              && (({1'b0, req_addr} + req_bytes) <= WIN_END);
    req_ok     = !misaligned && in_window;
  end

  // Rejected grants leave the pins idle, so memory sees a harmless read
  always_comb begin
    mem_address     = MEM_BASE;
    mem_access_size = 2'b11;
    mem_r_w         = 1'b0;
    mem_datain      = 32'h0;
    if (any_win && req_ok) begin
      mem_address     = req_addr;
      mem_access_size = req_size;
      mem_r_w         = req_we;
      mem_datain      = req_we ? ls_wdata : 32'h0;
    end
  end

  always_comb begin
    starve_nxt = 4'd0;
    if (if_req && !if_win) begin
      starve_nxt = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 4'd1;
    end
    owner_nxt = OWN_NONE;
    if (if_win) begin
      owner_nxt = OWN_IF;
    end else if (ls_win) begin
      owner_nxt = OWN_LS;
    end
    rsp_err_nxt  = any_win && !req_ok;
    rsp_we_nxt   = req_we;
    rsp_size_nxt = req_size;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= 4'd0;
      owner      <= OWN_NONE;
      rsp_err    <= 1'b0;
      rsp_we     <= 1'b0;
      rsp_size   <= 2'b11;
    end else begin
      starve_cnt <= starve_nxt;
      owner      <= owner_nxt;
      rsp_err    <= rsp_err_nxt;
      rsp_we     <= rsp_we_nxt;
      rsp_size   <= rsp_size_nxt;
    end
  end

  always_comb begin
    unique case (1'b1)
      rsp_size == 2'b11: ls_mask = 32'hFFFF_FFFF;
      rsp_size == 2'b10: ls_mask = 32'h0000_FFFF;
      default:           ls_mask = 32'h0000_00FF;
    endcase
    if_rvalid = (owner == OWN_IF);
    ls_rvalid = (owner == OWN_LS);
    if_err    = if_rvalid && rsp_err;
    ls_err    = ls_rvalid && rsp_err;
    // Read data is a passthrough of the memory output during the response cycle
    if_rdata  = (if_rvalid && !rsp_err) ? mem_dataout : 32'h0;
    ls_rdata  = (ls_rvalid && !rsp_err && !rsp_we) ? (mem_dataout & ls_mask) : 32'h0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random + directed bench for mem_port_arbiter.
// Big-endian memory model drives mem_dataout; scoreboard queues hold expected responses.
module tb_mem_port_arbiter;

  localparam logic [31:0] BASE  = 32'h80020000;
  localparam int          BYTES = 1048576;
  localparam int          LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [31:0] ls_addr = 32'h0;
  logic [1:0]  ls_size = 2'b11;
  logic [31:0] ls_wdata = 32'h0;
  logic        ls_gnt, ls_rvalid, ls_err;
  logic [31:0] ls_rdata;
  logic [31:0] mem_address, mem_datain;
  logic [1:0]  mem_access_size;
  logic        mem_r_w;
  logic [31:0] mem_dataout = 32'h0;

  always #5 clock = ~clock;

  mem_port_arbiter #(
    .MEM_BASE(BASE),
    .MEM_BYTES(BYTES),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_gnt(if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .if_err(if_err),
    .ls_req(ls_req),
    .ls_we(ls_we),
    .ls_addr(ls_addr),
    .ls_size(ls_size),
    .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata),
    .ls_err(ls_err),
    .mem_address(mem_address),
    .mem_datain(mem_datain),
    .mem_access_size(mem_access_size),
    .mem_r_w(mem_r_w),
    .mem_dataout(mem_dataout)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h at cycle %0d", nm, act, exp, cyc);
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  logic [7:0] env_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] env_byte(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] fit(input logic [31:0] w, input logic [1:0] s);
    if (s == 2'b11) return w;
    if (s == 2'b10) return {16'h0, w[31:16]};
    return {24'h0, w[31:24]};
  endfunction

  function automatic logic [31:0] rd_env(input logic [31:0] a, input logic [1:0] s);
    return fit({env_byte(a), env_byte(a + 32'd1), env_byte(a + 32'd2), env_byte(a + 32'd3)}, s);
  endfunction

  function automatic logic [31:0] rd_ref(input logic [31:0] a, input logic [1:0] s);
    return fit({ref_byte(a), ref_byte(a + 32'd1), ref_byte(a + 32'd2), ref_byte(a + 32'd3)}, s);
  endfunction

  task automatic wr_env(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    if (s == 2'b11) begin
      env_mem[a] = d[31:24];
      env_mem[a + 32'd1] = d[23:16];
      env_mem[a + 32'd2] = d[15:8];
      env_mem[a + 32'd3] = d[7:0];
    end else if (s == 2'b10) begin
      env_mem[a] = d[15:8];
      env_mem[a + 32'd1] = d[7:0];
    end else begin
      env_mem[a] = d[7:0];
    end
  endtask

  task automatic wr_ref(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    if (s == 2'b11) begin
      ref_mem[a] = d[31:24];
      ref_mem[a + 32'd1] = d[23:16];
      ref_mem[a + 32'd2] = d[15:8];
      ref_mem[a + 32'd3] = d[7:0];
    end else if (s == 2'b10) begin
      ref_mem[a] = d[15:8];
      ref_mem[a + 32'd1] = d[7:0];
    end else begin
      ref_mem[a] = d[7:0];
    end
  endtask

  // Memory model: samples pins at posedge, data valid next cycle,
  // unused upper bits of narrow reads are junk; writes land on the negedge.
  logic        w_pend = 1'b0;
  logic [31:0] w_addr = 32'h0, w_data = 32'h0;
  logic [1:0]  w_size = 2'b11;

  always @(posedge clock) begin
    logic [31:0] m;
    m = fit(32'hFFFF_FFFF, mem_access_size);
    mem_dataout <= (rd_env(mem_address, mem_access_size) & m) | ($urandom & ~m);
    w_pend <= mem_r_w;
    w_addr <= mem_address;
    w_data <= mem_datain;
    w_size <= mem_access_size;
  end

  always @(negedge clock) if (w_pend) wr_env(w_addr, w_size, w_data);

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          due;
  } rsp_t;

  rsp_t if_q[$];
  rsp_t ls_q[$];
  int   losses = 0;
  bit   g_if = 0, g_ls = 0, s_if = 0, s_ls = 0;

  function automatic bit acc_ok(input logic [31:0] a, input logic [1:0] s);
    longint n;
    n = (s == 2'b11) ? 4 : (s == 2'b10) ? 2 : 1;
    if (s == 2'b11 && a % 4 != 0) return 0;
    if (s == 2'b10 && a % 2 != 0) return 0;
    return longint'(a) >= longint'(BASE) && longint'(a) + n <= longint'(BASE) + BYTES;
  endfunction

  task automatic eval();
    bit   ei, el, ok;
    rsp_t r;
    #1;
    ei = if_req && (!ls_req || losses == LIMIT);
    el = ls_req && !ei;
    s_if = if_gnt;
    s_ls = ls_gnt;
    g_if = ei;
    g_ls = el;
    chk("if_gnt", 32'(if_gnt), 32'(ei));
    chk("ls_gnt", 32'(ls_gnt), 32'(el));
    losses = (if_req && !ei) ? ((losses < LIMIT) ? losses + 1 : LIMIT) : 0;
    if (ei) begin
      ok = acc_ok(if_addr, 2'b11);
      r.d = ok ? rd_ref(if_addr, 2'b11) : 32'h0;
      r.e = !ok;
      r.due = cyc + 1;
      if_q.push_back(r);
      if (!ok) chk("if_rej_addr", mem_address, BASE);
    end
    if (el) begin
      ok = acc_ok(ls_addr, ls_size);
      r.d = (ok && !ls_we) ? rd_ref(ls_addr, ls_size) : 32'h0;
      r.e = !ok;
      r.due = cyc + 1;
      ls_q.push_back(r);
      if (ok && ls_we) begin
        wr_ref(ls_addr, ls_size, ls_wdata);
        chk("wr_r_w", 32'(mem_r_w), 32'd1);
      end
      if (!ok) begin
        chk("rej_r_w", 32'(mem_r_w), 32'd0);
        chk("rej_addr", mem_address, BASE);
      end
    end
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    if_req = 1'b0;
    ls_req = 1'b0;
    repeat (n) begin
      eval();
      adv();
    end
  endtask

  rsp_t mr;

  always @(negedge clock) begin
    if (!reset) begin
      if (if_q.size() == 0) begin
        chk("if_rvalid_unexpected", 32'(if_rvalid), 32'd0);
      end else if (if_rvalid) begin
        mr = if_q.pop_front();
        chk("if_latency", 32'(cyc), 32'(mr.due));
        chk("if_rdata", if_rdata, mr.d);
        chk("if_err", 32'(if_err), 32'(mr.e));
      end else if (if_q[0].due <= cyc) begin
        chk("if_rvalid_missing", 32'(if_rvalid), 32'd1);
        void'(if_q.pop_front());
      end
      if (ls_q.size() == 0) begin
        chk("ls_rvalid_unexpected", 32'(ls_rvalid), 32'd0);
      end else if (ls_rvalid) begin
        mr = ls_q.pop_front();
        chk("ls_latency", 32'(cyc), 32'(mr.due));
        chk("ls_rdata", ls_rdata, mr.d);
        chk("ls_err", 32'(ls_err), 32'(mr.e));
      end else if (ls_q[0].due <= cyc) begin
        chk("ls_rvalid_missing", 32'(ls_rvalid), 32'd1);
        void'(ls_q.pop_front());
      end
    end
  end

  function automatic logic [31:0] pick_if();
    logic [31:0] a;
    a = BASE + (32'($urandom_range(0, 15)) << 2);
    case ($urandom_range(0, 11))
      0: a = a + 32'd2;
      1: a = BASE - 32'd4;
      2: a = BASE + 32'(BYTES) - 32'd4;
      3: a = BASE + 32'(BYTES);
      default: ;
    endcase
    return a;
  endfunction

  task automatic pick_ls(output logic [31:0] a, output logic [1:0] s);
    s = 2'($urandom_range(0, 3));
    a = BASE + 32'($urandom_range(0, 31));
    case ($urandom_range(0, 11))
      0: a = BASE - 32'd1;
      1: a = BASE + 32'(BYTES) - 32'd1;
      2: a = BASE + 32'(BYTES) - 32'd2;
      3: a = 32'hFFFF_FFFE;
      default: ;
    endcase
  endtask

  logic [31:0] t5_exp [3];

  initial begin
    t5_exp[0] = 32'h3C1D0004;
    t5_exp[1] = 32'h11223344;
    t5_exp[2] = 32'h55667788;
    for (int k = 0; k < 3; k++) begin
      wr_env(BASE + 32'(4 * k), 2'b11, t5_exp[k]);
      wr_ref(BASE + 32'(4 * k), 2'b11, t5_exp[k]);
    end

    @(posedge clock);
    #1;
    chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_ls_rvalid", 32'(ls_rvalid), 32'd0);
    chk("rst_if_err", 32'(if_err), 32'd0);
    chk("rst_ls_err", 32'(ls_err), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_ls_rdata", ls_rdata, 32'h0);
    chk("rst_mem_address", mem_address, BASE);
    chk("rst_mem_size", 32'(mem_access_size), 32'd3);
    chk("rst_mem_r_w", 32'(mem_r_w), 32'd0);
    chk("rst_mem_datain", mem_datain, 32'h0);
    adv();
    reset = 1'b0;
    idle(1);

    // T1
    if_req = 1'b1;
    if_addr = BASE;
    eval();
    chk("t1_gnt", 32'(if_gnt), 32'd1);
    adv();
    chk("t1_rvalid", 32'(if_rvalid), 32'd1);
    chk("t1_rdata", if_rdata, 32'h3C1D0004);
    chk("t1_err", 32'(if_err), 32'd0);
    idle(1);

    // T2
    ls_req = 1'b1;
    ls_we = 1'b1;
    ls_addr = BASE + 32'h10;
    ls_size = 2'b11;
    ls_wdata = 32'hDEADBEEF;
    eval();
    adv();
    ls_we = 1'b0;
    ls_addr = BASE + 32'h12;
    ls_size = 2'b00;
    eval();
    adv();
    chk("t2_byte", ls_rdata, 32'h000000BE);
    idle(1);

    // T3
    if_req = 1'b1;
    if_addr = BASE;
    ls_req = 1'b1;
    ls_we = 1'b0;
    ls_addr = BASE + 32'd4;
    ls_size = 2'b11;
    for (int i = 0; i < 10; i++) begin
      eval();
      chk("t3_grant", 32'({s_if, s_ls}), (i % 5 == 4) ? 32'd2 : 32'd1);
      adv();
    end
    idle(1);

    // T4
    ls_req = 1'b1;
    ls_we = 1'b0;
    ls_addr = BASE + 32'd1;
    ls_size = 2'b10;
    eval();
    adv();
    chk("t4a_err", 32'({ls_rvalid, ls_err}), 32'd3);
    chk("t4a_rdata", ls_rdata, 32'h0);
    ls_addr = 32'h80120000;
    ls_size = 2'b11;
    eval();
    adv();
    chk("t4b_err", 32'({ls_rvalid, ls_err}), 32'd3);
    chk("t4b_rdata", ls_rdata, 32'h0);
    idle(1);

    // T5
    if_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if_addr = BASE + 32'(4 * k);
      eval();
      adv();
      chk("t5_rvalid", 32'(if_rvalid), 32'd1);
      chk("t5_rdata", if_rdata, t5_exp[k]);
    end
    idle(1);

    // T6
    if_req = 1'b1;
    if_addr = BASE + 32'd4;
    eval();
    @(posedge clock);
    #3;
    chk("t6_rvalid_pre", 32'(if_rvalid), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("t6_ls_rvalid", 32'(ls_rvalid), 32'd0);
    if_req = 1'b0;
    if_q.delete();
    ls_q.delete();
    losses = 0;
    g_if = 0;
    g_ls = 0;
    adv();
    chk("t6_held", 32'({if_rvalid, ls_rvalid}), 32'd0);
    reset = 1'b0;
    idle(3);

    for (int i = 0; i < 400; i++) begin
      if (!(if_req && !g_if)) begin
        if_req = ($urandom_range(0, 3) != 0);
        if_addr = pick_if();
      end
      if (!(ls_req && !g_ls)) begin
        ls_req = ($urandom_range(0, 3) != 0);
        ls_we = 1'($urandom_range(0, 1));
        pick_ls(ls_addr, ls_size);
        ls_wdata = $urandom;
      end
      eval();
      adv();
    end
    idle(3);
    chk("if_q_drained", 32'(if_q.size()), 32'd0);
    chk("ls_q_drained", 32'(ls_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
